// File: rtl/psram_byte_requester.sv
// Byte-wide bus client for one PSRAM channel: issues 4-beat bursts, extracts the addressed byte.
// Optional read watchdog: define PSRAM_REQ_TIMEOUT_EN.
module psram_byte_requester #(
    parameter int CMD_INTERVAL = 14,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_calib,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [22:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        mem_cmd,
    output logic        mem_cmd_en,
    output logic [20:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_data_mask,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_data_valid
);

    typedef enum logic [2:0] {WAIT_CALIB, IDLE, WBEAT, RWAIT, GAP} state_t;

    state_t      state, state_d;
    logic [7:0]  gap;
    logic [1:0]  beat, lane, cnt;
    logic [7:0]  rbyte, lane_byte;
    logic        accept, last_beat, rd_done;

    function automatic logic [3:0] mask_for(input logic [1:0] k,
                                            input logic [1:0] b,
                                            input logic [1:0] l);
        logic [3:0] m;
        m = 4'b1111;
        if (k == b) m[l] = 1'b0;
        return m;
    endfunction

    assign req_ready = (state == IDLE) && (gap == 8'd0);
    assign accept    = req_valid && req_ready;
    assign lane_byte = mem_rd_data[{lane, 3'b000} +: 8];
    assign last_beat = (state == RWAIT) && mem_rd_data_valid && (cnt == 2'd3);

`ifdef PSRAM_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    logic          timeout;
    assign timeout = (state == RWAIT) && !last_beat && (tcnt == TW'(TIMEOUT - 1));
    assign rd_done = last_beat || timeout;
`else
    assign rd_done = last_beat;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            WAIT_CALIB: if (init_calib) state_d = IDLE;
            IDLE:       if (accept) state_d = req_write ? WBEAT : RWAIT;
            WBEAT:      if (cnt == 2'd3) state_d = GAP;
            RWAIT:      if (rd_done) state_d = GAP;
            // leave one cycle early so IDLE is reached exactly as the gap expires
            GAP:        if (gap <= 8'd1) state_d = IDLE;
            default:    state_d = WAIT_CALIB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_CALIB;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap           <= 8'd0;
            beat          <= 2'd0;
            lane          <= 2'd0;
            cnt           <= 2'd0;
            rbyte         <= 8'd0;
            rdata         <= 8'd0;
            rdata_valid   <= 1'b0;
            mem_cmd       <= 1'b0;
            mem_cmd_en    <= 1'b0;
            mem_addr      <= 21'd0;
            mem_wr_data   <= 32'd0;
            mem_data_mask <= 4'b1111;
`ifdef PSRAM_REQ_TIMEOUT_EN
            tcnt          <= '0;
            err           <= 1'b0;
`endif
        end else begin
            mem_cmd_en  <= 1'b0;
            rdata_valid <= 1'b0;
            if (gap != 8'd0) gap <= gap - 8'd1;
            if (accept) begin
                beat       <= req_addr[3:2];
                lane       <= req_addr[1:0];
                cnt        <= 2'd0;
                mem_addr   <= {req_addr[22:4], 2'b00};
                mem_cmd    <= req_write;
                mem_cmd_en <= 1'b1;
                gap        <= 8'(CMD_INTERVAL - 1);
`ifdef PSRAM_REQ_TIMEOUT_EN
                tcnt       <= '0;
`endif
                if (req_write) begin
                    mem_wr_data   <= {4{req_wdata}};
                    mem_data_mask <= mask_for(2'd0, req_addr[3:2], req_addr[1:0]);
                end
            end else if (state == WBEAT) begin
                if (cnt == 2'd3) begin
                    mem_data_mask <= 4'b1111;
                end else begin
                    cnt           <= cnt + 2'd1;
                    mem_data_mask <= mask_for(cnt + 2'd1, beat, lane);
                end
            end else if (state == RWAIT) begin
`ifdef PSRAM_REQ_TIMEOUT_EN
                tcnt <= tcnt + 1'b1;
                if (timeout) begin
                    rdata       <= 8'hFF;
                    rdata_valid <= 1'b1;
                    err         <= 1'b1;
                end
`endif
                if (mem_rd_data_valid) begin
                    cnt <= cnt + 2'd1;
                    if (cnt == beat) rbyte <= lane_byte;
                    if (cnt == 2'd3) begin
                        rdata       <= (beat == 2'd3) ? lane_byte : rbyte;
                        rdata_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_psram_byte_requester.sv
// Directed bench for psram_byte_requester: reset, calibration, read/write bursts,
// command spacing, stray beats, watchdog (when enabled) and async reset.
module tb_psram_byte_requester;

    logic        clk = 1'b0;
    logic        rst_n, init_calib, req_valid, req_write;
    logic        req_ready, rdata_valid, err;
    logic        mem_cmd, mem_cmd_en, mem_rd_data_valid;
    logic [22:0] req_addr;
    logic [7:0]  req_wdata, rdata;
    logic [20:0] mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic [3:0]  mem_data_mask;

    int n_vec = 0, n_bad = 0, cyc = 0, rv_cnt = 0;

    always #5 clk = ~clk;

    psram_byte_requester dut (
        .clk(clk), .rst_n(rst_n), .init_calib(init_calib),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .mem_cmd(mem_cmd), .mem_cmd_en(mem_cmd_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_data_mask(mem_data_mask),
        .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid)
    );

    always @(negedge clk) if (rdata_valid) rv_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 60) begin
            step();
            n++;
        end
        check(tag, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [22:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic beats(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data = base + 32'(i) * 32'h01010101;
            step();
        end
        mem_rd_data_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, "_rv"}, {31'd0, rdata_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_cmd"}, {30'd0, mem_cmd, mem_cmd_en}, 32'd0);
        check({tag, "_addr"}, {11'd0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, mem_wr_data, 32'd0);
        check({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
        check({tag, "_mask"}, {28'd0, mem_data_mask}, 32'hF);
    endtask

    initial begin
        int r0, n, acc1, acc2, en1, en2, seen_en, seen_rdy;
        logic [3:0] wm [4];
        wm = '{4'hF, 4'hF, 4'hF, 4'hB};
        rst_n = 1'b0; init_calib = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rd_data = '0; mem_rd_data_valid = 1'b0;
        repeat (3) step();
        check_reset_vals("rst");

        rst_n = 1'b1;
        seen_en = 0; seen_rdy = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (mem_cmd_en) seen_en++;
            if (req_ready) seen_rdy++;
        end
        check("calib_en", 32'(seen_en), 32'd0);
        check("calib_rdy", 32'(seen_rdy), 32'd0);
        init_calib = 1'b1;
        step();
        check("calib_done", {31'd0, req_ready}, 32'd1);

        // read 0x000005: beat 1, lane 1
        r0 = rv_cnt;
        issue(1'b0, 23'h000005, 8'h00);
        check("rd1_en", {31'd0, mem_cmd_en}, 32'd1);
        check("rd1_cmd", {31'd0, mem_cmd}, 32'd0);
        check("rd1_addr", {11'd0, mem_addr}, 32'd0);
        check("rd1_busy", {31'd0, req_ready}, 32'd0);
        beats(4, 32'h64656667);
        check("rd1_rv", {31'd0, rdata_valid}, 32'd1);
        check("rd1_data", {24'd0, rdata}, 32'd103);
        step();
        check("rd1_pulse", 32'(rv_cnt - r0), 32'd1);
        wait_ready("rd1_gap");

        // write 0x00000E: beat 3, lane 2
        issue(1'b1, 23'h00000E, 8'h5A);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("wr_en%0d", k), {31'd0, mem_cmd_en}, (k == 0) ? 32'd1 : 32'd0);
            check($sformatf("wr_cmd%0d", k), {31'd0, mem_cmd}, 32'd1);
            check($sformatf("wr_addr%0d", k), {11'd0, mem_addr}, 32'd0);
            check($sformatf("wr_data%0d", k), mem_wr_data, 32'h5A5A5A5A);
            check($sformatf("wr_mask%0d", k), {28'd0, mem_data_mask}, {28'd0, wm[k]});
            step();
        end
        check("wr_mask_end", {28'd0, mem_data_mask}, 32'hF);
        wait_ready("wr_gap");

        // back-to-back: read 0x123456 then a write held valid
        acc1 = cyc;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 23'h123456;
        step();
        en1 = cyc;
        check("sp_en1", {31'd0, mem_cmd_en}, 32'd1);
        check("sp_addr", {11'd0, mem_addr}, 32'h048D14);
        check("sp_cmd", {31'd0, mem_cmd}, 32'd0);
        req_write = 1'b1; req_addr = 23'h000021; req_wdata = 8'h3C;
        beats(4, 32'hA0B0C0D0);
        check("sp_rdata", {24'd0, rdata}, 32'hB1);
        check("sp_hold", {11'd0, mem_addr}, 32'h048D14);
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        acc2 = cyc;
        step();
        en2 = cyc;
        req_valid = 1'b0;
        check("sp_acc", 32'(acc2 - acc1), 32'd14);
        check("sp_en2", {31'd0, mem_cmd_en}, 32'd1);
        check("sp_enspace", 32'(en2 - en1), 32'd14);
        check("sp_wcmd", {31'd0, mem_cmd}, 32'd1);
        check("sp_wmask", {28'd0, mem_data_mask}, 32'hD);
        wait_ready("sp_gap");

        // stray beats in IDLE, then 6 beats for a 0x000008 read
        r0 = rv_cnt;
        beats(3, 32'h90909090);
        check("stray_rdy", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 23'h000008, 8'h00);
        beats(6, 32'h40404040);
        repeat (4) step();
        check("stray_data", {24'd0, rdata}, 32'h42);
        check("stray_pulse", 32'(rv_cnt - r0), 32'd1);
        wait_ready("stray_gap");

        // read with no beats returned
        issue(1'b0, 23'h000004, 8'h00);
        n = 0;
        while (!rdata_valid && n < 100) begin
            step();
            n++;
        end
`ifdef PSRAM_REQ_TIMEOUT_EN
        check("to_lat", 32'(n), 32'd64);
        check("to_rdata", {24'd0, rdata}, 32'hFF);
        check("to_err", {31'd0, err}, 32'd1);
        wait_ready("to_gap");
        issue(1'b0, 23'h000000, 8'h00);
        step();
`else
        check("nto_wait", 32'(n), 32'd100);
        check("nto_err", {31'd0, err}, 32'd0);
`endif

        // async reset while waiting on a read
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        mem_rd_data_valid = 1'b1;
        mem_rd_data = 32'hEEEEEEEE;
        step();
        step();
        rst_n = 1'b1;
        step();
        mem_rd_data_valid = 1'b0;
        wait_ready("arst_rdy");
        issue(1'b0, 23'h000005, 8'h00);
        beats(4, 32'h64656667);
        check("arst_rv", {31'd0, rdata_valid}, 32'd1);
        check("arst_data", {24'd0, rdata}, 32'd103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/psram_byte_requester.md
# psram_byte_requester

Initiator-side client for one channel of the two-channel PSRAM memory interface. Converts single-byte read/write requests from the 8-bit system bus into burst-aligned 32-bit PSRAM commands. Drives `cmd`, `cmd_en`, `addr`, `wr_data` and `data_mask`, then collects the 4-beat read burst and returns the addressed byte. One instance is placed per channel, between the bus arbiter and the PSRAM interface.

## Interface
- `CMD_INTERVAL`, default 14: minimum clocks between successive `mem_cmd_en` pulses, counted from the issuing cycle. Valid range is 14–255.
- `TIMEOUT`, default 64: read watchdog limit in clocks. Used only with `PSRAM_REQ_TIMEOUT_EN`.
- `clk` in 1: system clock. The same clock drives the PSRAM interface `clk`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init_calib` in 1: calibration done, from the PSRAM interface.
- `req_valid` in 1: bus request valid.
- `req_ready` out 1: request accepted on a cycle where `req_valid & req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 23: byte address.
- `req_wdata` in 8: write byte.
- `rdata` out 8: read byte. Held until the next read completes.
- `rdata_valid` out 1: one-cycle pulse when `rdata` is updated.
- `err` out 1: sticky read-timeout flag.
- `mem_cmd` out 1: 1 = write, 0 = read.
- `mem_cmd_en` out 1: one-cycle command strobe.
- `mem_addr` out 21: burst-aligned word address.
- `mem_wr_data` out 32: write beat data.
- `mem_data_mask` out 4: per-byte mask, 1 = byte not written.
- `mem_rd_data` in 32: read beat data.
- `mem_rd_data_valid` in 1: read beat valid.

## Operation
- **FSM states**: WAIT_CALIB, IDLE, WBEAT, RWAIT, GAP.
- **Reset** (values held while `rst_n` is low):
  - State is WAIT_CALIB.
  - `req_ready`, `rdata_valid`, `err`, `mem_cmd`, `mem_cmd_en` are 0.
  - `mem_addr`, `mem_wr_data`, `rdata` are 0.
  - `mem_data_mask` is 4'b1111.
  - Gap counter is 0.
- **Reset mid-operation**: aborts immediately. No partial state survives, and stray beats arriving after reset are ignored.
- **WAIT_CALIB**: stays until `init_calib` = 1, then goes to IDLE. Never re-entered without reset.
- **IDLE**:
  - `req_ready` = 1 only in IDLE with the gap counter at 0.
  - On acceptance the block latches the request.
  - `mem_addr` = {`req_addr`[22:4], 2'b00}.
  - Beat index b = `req_addr`[3:2]; byte lane l = `req_addr`[1:0]. Lane l maps to `mem_rd_data`/`mem_wr_data` bits [8l+7:8l].
- **Write command**:
  - Next cycle: `mem_cmd_en` = 1, `mem_cmd` = 1.
  - Beats 0–3 are driven on the `mem_cmd_en` cycle and the following 3 cycles (WBEAT).
  - Each beat drives `mem_wr_data` = {4{`req_wdata`}}.
  - `mem_data_mask` = 4'b1111, except on beat b, where bit l = 0.
  - After beat 3: `mem_data_mask` returns to 4'b1111, then go to GAP.
- **Read command**:
  - Next cycle: `mem_cmd_en` = 1, `mem_cmd` = 0, then RWAIT.
  - In RWAIT, the block counts beats on `mem_rd_data_valid` and captures byte l of beat b.
  - After the 4th beat: `rdata_valid` pulses, then go to GAP.
- **GAP**: waits until the gap counter is 0, then goes to IDLE.
  - The counter loads `CMD_INTERVAL`−1 on each `mem_cmd_en` cycle and decrements to 0.
- **Ignored inputs**:
  - `mem_rd_data_valid` outside RWAIT.
  - Beats beyond the 4th.
- **One transaction in flight**: `req_valid` is ignored while `req_ready` = 0. The requester must hold its request until it is accepted.

## Timing
- Acceptance at cycle A gives `mem_cmd_en` at A+1.
- Write beats occupy A+1..A+4.
- Read: `rdata_valid` is asserted the cycle after the 4th beat is sampled.
- Earliest next acceptance: A+`CMD_INTERVAL`, so that the next `mem_cmd_en` is at A+1+`CMD_INTERVAL`.
- Back-to-back requests are therefore spaced exactly `CMD_INTERVAL` clocks when the read burst returns early enough.
- `mem_addr` and `mem_cmd` stay stable from the `mem_cmd_en` cycle until the next acceptance.

## Configuration
- Macro: `PSRAM_REQ_TIMEOUT_EN`.
- **Defined**:
  - A read watchdog counts clocks in RWAIT.
  - If 4 beats have not arrived after `TIMEOUT` clocks, the block sets `rdata` = 8'hFF, pulses `rdata_valid`, sets `err` = 1 (sticky until reset) and goes to GAP.
  - Late beats are ignored.
- **Not defined**: `err` is tied to 0 and RWAIT waits indefinitely.

## Test plan
- Reset, hold `init_calib` = 0 for 50 clocks → `req_ready` stays 0 with no `mem_cmd_en`. Raise `init_calib` → `req_ready` = 1 the next cycle.
- Read `req_addr` = 23'h000005, memory returns beats {100,101,102,103}, then +1 per byte per beat → `mem_addr` = 0, `mem_cmd` = 0, `rdata` = 8'd103 with a single-cycle `rdata_valid`.
- Write `req_addr` = 23'h00000E, `req_wdata` = 8'h5A → `mem_cmd` = 1, `mem_addr` = 0, `mem_wr_data` = 32'h5A5A5A5A on 4 beats. Masks are 4'b1111, 4'b1111, 4'b1111, 4'b1011.
- Read `req_addr` = 23'h123456 → `mem_addr` = 21'h048D14. A second request held valid is accepted exactly 14 clocks after the first; `mem_cmd_en` spacing is 14.
- Inject stray `mem_rd_data_valid` pulses in IDLE and 6 beats in RWAIT → only the first 4 beats count, and `rdata_valid` pulses once.
- With `PSRAM_REQ_TIMEOUT_EN`, issue a read and return no beats → after 64 clocks `rdata` = 8'hFF, `rdata_valid` pulses and `err` = 1. Deassert `rst_n` mid-RWAIT → all outputs are at reset values immediately.
